// File: rtl/divider_32bit_if.sv
// Handshake and operand/result bundle between the core and the multi-cycle divider.
interface divider_32bit_if #(
  parameter int unsigned size = 32
);
  logic            start;
  logic            sign;
  logic [size-1:0] A;
  logic [size-1:0] B;
  logic [size-1:0] quo;
  logic [size-1:0] rem;
  logic            busy;
  logic            done;
  logic            dvz;

  modport master (
    output start, sign, A, B,
    input  quo, rem, busy, done, dvz
  );

  modport slave (
    input  start, sign, A, B,
    output quo, rem, busy, done, dvz
  );
endinterface

// File: rtl/divider_32bit.sv
// Restoring divider for MIPS div/divu: one quotient bit per clock, results
// registered one cycle after the last iteration. Trial subtraction uses adder_32bit.

module adder_32bit #(
  parameter int unsigned width = 32
) (
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             Ctr,
  output logic [width-1:0] S,
  output logic             sltu
);
  logic [width-1:0] b_eff;
  logic [width:0]   full;

  // Ctr=1 selects A - B; sltu is the unsigned borrow (A < B).
  always_comb begin
    b_eff = Ctr ? ~B : B;
    full  = {1'b0, A} + {1'b0, b_eff} + (width+1)'(Ctr);
    S     = full[width-1:0];
    sltu  = Ctr & ~full[width];
  end
endmodule

module divider_32bit #(
  parameter int unsigned size = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  divider_32bit_if.slave       bus
);
  localparam int unsigned W     = size;
  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     q_sh, q_sh_nxt;
  logic [W-1:0]     r_acc, r_acc_nxt;
  logic [W-1:0]     b_mag, b_mag_nxt;
  logic [W-1:0]     a_raw, a_raw_nxt;
  logic             neg_q, neg_q_nxt;
  logic             neg_r, neg_r_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [W-1:0]     quo_r, quo_nxt;
  logic [W-1:0]     rem_r, rem_nxt;
  logic             busy_r, busy_nxt;
  logic             done_r, done_nxt;
  logic             dvz_r, dvz_nxt;

  logic [W-1:0]     shifted;
  logic [W-1:0]     trial;
  logic             borrow;
  logic             a_neg, b_neg;
  logic [W-1:0]     q_fin, r_fin;

  assign shifted = {r_acc[W-2:0], q_sh[W-1]};

  adder_32bit #(.width(W)) u_sub (
    .A    (shifted),
    .B    (b_mag),
    .Ctr  (1'b1),
    .S    (trial),
    .sltu (borrow)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt = state;
    q_sh_nxt  = q_sh;
    r_acc_nxt = r_acc;
    b_mag_nxt = b_mag;
    a_raw_nxt = a_raw;
    neg_q_nxt = neg_q;
    neg_r_nxt = neg_r;
    cnt_nxt   = cnt;
    quo_nxt   = quo_r;
    rem_nxt   = rem_r;
    busy_nxt  = busy_r;
    done_nxt  = 1'b0;
    dvz_nxt   = dvz_r;

    a_neg = bus.sign & bus.A[W-1];
    b_neg = bus.sign & bus.B[W-1];
    q_fin = neg_q ? (~q_sh + W'(1)) : q_sh;
    r_fin = neg_r ? (~r_acc + W'(1)) : r_acc;

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          q_sh_nxt  = a_neg ? (~bus.A + W'(1)) : bus.A;
          b_mag_nxt = b_neg ? (~bus.B + W'(1)) : bus.B;
          a_raw_nxt = bus.A;
          neg_q_nxt = a_neg ^ b_neg;
          neg_r_nxt = a_neg;
          r_acc_nxt = '0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        if (cnt != LAST) begin
          r_acc_nxt = borrow ? shifted : trial;
          q_sh_nxt  = {q_sh[W-2:0], ~borrow};
          cnt_nxt   = cnt + CNT_W'(1);
        end else begin
          // A zero divisor overrides the sign fix-up for both div and divu.
          if (b_mag == '0) begin
            quo_nxt = '1;
            rem_nxt = a_raw;
            dvz_nxt = 1'b1;
          end else begin
            quo_nxt = q_fin;
            rem_nxt = r_fin;
            dvz_nxt = 1'b0;
          end
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      q_sh   <= '0;
      r_acc  <= '0;
      b_mag  <= '0;
      a_raw  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cnt    <= '0;
      quo_r  <= '0;
      rem_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dvz_r  <= 1'b0;
    end else begin
      state  <= state_nxt;
      q_sh   <= q_sh_nxt;
      r_acc  <= r_acc_nxt;
      b_mag  <= b_mag_nxt;
      a_raw  <= a_raw_nxt;
      neg_q  <= neg_q_nxt;
      neg_r  <= neg_r_nxt;
      cnt    <= cnt_nxt;
      quo_r  <= quo_nxt;
      rem_r  <= rem_nxt;
      busy_r <= busy_nxt;
      done_r <= done_nxt;
      dvz_r  <= dvz_nxt;
    end
  end

  assign bus.quo  = quo_r;
  assign bus.rem  = rem_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.dvz  = dvz_r;
endmodule

// File: tb/tb_divider_32bit.sv
// Directed bench for divider_32bit: arithmetic vectors, handshake timing and reset.
module tb_divider_32bit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  divider_32bit_if bus ();

  divider_32bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Call at posedge+#1; returns at posedge+#1 just after the sampling edge.
  task automatic start_op(input logic sg, input logic [31:0] a, input logic [31:0] b);
    bus.sign  = sg;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.sign  = ~sg;
    bus.A     = ~a;
    bus.B     = ~b;
  endtask

  task automatic wait_done(output int cyc, output int busy_cnt, output bit overlap);
    cyc      = 0;
    busy_cnt = bus.busy ? 1 : 0;
    overlap  = 1'b0;
    while (!bus.done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.busy && bus.done) overlap = 1'b1;
      if (bus.busy && !bus.done) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.sign = 1'b0; bus.A = '0; bus.B = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({bus.quo, bus.rem, bus.busy, bus.done, bus.dvz} !== 67'd0) begin
      fails++;
      $display("FAIL reset_outputs: quo=%h rem=%h busy=%b done=%b dvz=%b, need all 0",
               bus.quo, bus.rem, bus.busy, bus.done, bus.dvz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unsigned;
    int cyc, bc; bit ov;
    start_op(1'b0, 32'd100, 32'd7);
    wait_done(cyc, bc, ov);
    tests++;
    if (cyc !== 33) begin fails++; $display("FAIL unsigned_latency: got %0d edges, need 33", cyc); end
    tests++;
    if (bc !== 33 || ov) begin fails++; $display("FAIL unsigned_busy: busy %0d cycles overlap=%b, need 33 and 0", bc, ov); end
    tests++;
    if ({bus.quo, bus.rem, bus.dvz} !== {32'd14, 32'd2, 1'b0}) begin
      fails++; $display("FAIL unsigned_100_7: quo=%h rem=%h dvz=%b, need 0000000e 00000002 0", bus.quo, bus.rem, bus.dvz);
    end
    @(posedge clk);
    #1;
    tests++;
    if ({bus.done, bus.busy, bus.quo} !== {1'b0, 1'b0, 32'd14}) begin
      fails++; $display("FAIL done_pulse: done=%b busy=%b quo=%h, need 0 0 0000000e", bus.done, bus.busy, bus.quo);
    end
  endtask

  task automatic test_signed;
    int cyc, bc; bit ov;
    start_op(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_done(cyc, bc, ov);
    tests++;
    if ({bus.quo, bus.rem, bus.dvz} !== {32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0}) begin
      fails++; $display("FAIL signed_m100_7: quo=%h rem=%h dvz=%b, need fffffff2 fffffffe 0", bus.quo, bus.rem, bus.dvz);
    end
    start_op(1'b1, 32'd100, 32'hFFFF_FFF9);
    wait_done(cyc, bc, ov);
    tests++;
    if ({bus.quo, bus.rem, bus.dvz} !== {32'hFFFF_FFF2, 32'd2, 1'b0}) begin
      fails++; $display("FAIL signed_100_m7: quo=%h rem=%h dvz=%b, need fffffff2 00000002 0", bus.quo, bus.rem, bus.dvz);
    end
  endtask

  task automatic test_div_zero;
    int cyc, bc; bit ov;
    for (int s = 0; s < 2; s++) begin
      start_op(1'(s), 32'h1234_5678, 32'd0);
      wait_done(cyc, bc, ov);
      tests++;
      if ({bus.quo, bus.rem, bus.dvz} !== {32'hFFFF_FFFF, 32'h1234_5678, 1'b1}) begin
        fails++; $display("FAIL div_zero_sign%0d: quo=%h rem=%h dvz=%b, need ffffffff 12345678 1", s, bus.quo, bus.rem, bus.dvz);
      end
    end
  endtask

  task automatic test_edges;
    int cyc, bc; bit ov;
    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, bc, ov);
    tests++;
    if ({bus.quo, bus.rem, bus.dvz} !== {32'h8000_0000, 32'd0, 1'b0}) begin
      fails++; $display("FAIL edge_min_div_m1: quo=%h rem=%h dvz=%b, need 80000000 00000000 0", bus.quo, bus.rem, bus.dvz);
    end
    start_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, bc, ov);
    tests++;
    if ({bus.quo, bus.rem} !== {32'd0, 32'h8000_0000}) begin
      fails++; $display("FAIL edge_unsigned_big: quo=%h rem=%h, need 00000000 80000000", bus.quo, bus.rem);
    end
    start_op(1'b0, 32'hFFFF_FFFF, 32'd1);
    wait_done(cyc, bc, ov);
    tests++;
    if ({bus.quo, bus.rem} !== {32'hFFFF_FFFF, 32'd0}) begin
      fails++; $display("FAIL edge_max_div_1: quo=%h rem=%h, need ffffffff 00000000", bus.quo, bus.rem);
    end
  endtask

  task automatic test_start_ignored;
    int cyc, bc; bit ov;
    start_op(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    start_op(1'b0, 32'd50, 32'd5);
    wait_done(cyc, bc, ov);
    tests++;
    if (cyc !== 23) begin fails++; $display("FAIL ignored_start_timing: done %0d edges after restart attempt, need 23", cyc); end
    tests++;
    if ({bus.quo, bus.rem} !== {32'd14, 32'd2}) begin
      fails++; $display("FAIL ignored_start_result: quo=%h rem=%h, need 0000000e 00000002", bus.quo, bus.rem);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, bc; bit ov;
    start_op(1'b0, 32'd1000, 32'd9);
    wait_done(cyc, bc, ov);
    tests++;
    if ({bus.quo, bus.rem} !== {32'd111, 32'd1}) begin
      fails++; $display("FAIL b2b_first: quo=%h rem=%h, need 0000006f 00000001", bus.quo, bus.rem);
    end
    start_op(1'b0, 32'd77, 32'd10);
    tests++;
    if ({bus.busy, bus.done, bus.quo, bus.rem} !== {1'b1, 1'b0, 32'd111, 32'd1}) begin
      fails++; $display("FAIL b2b_accept: busy=%b done=%b quo=%h rem=%h, need 1 0 0000006f 00000001",
                        bus.busy, bus.done, bus.quo, bus.rem);
    end
    wait_done(cyc, bc, ov);
    tests++;
    if (cyc !== 33 || {bus.quo, bus.rem} !== {32'd7, 32'd7}) begin
      fails++; $display("FAIL b2b_second: edges=%0d quo=%h rem=%h, need 33 00000007 00000007", cyc, bus.quo, bus.rem);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, bc; bit ov;
    bit seen_done;
    start_op(1'b0, 32'd500, 32'd3);
    repeat (16) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.quo, bus.rem, bus.busy, bus.done, bus.dvz} !== 67'd0) begin
      fails++; $display("FAIL reset_mid_async: quo=%h rem=%h busy=%b done=%b dvz=%b, need all 0",
                        bus.quo, bus.rem, bus.busy, bus.done, bus.dvz);
    end
    seen_done = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    tests++;
    if (seen_done) begin fails++; $display("FAIL reset_mid_hold: busy/done active during reset, need 0"); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_op(1'b0, 32'd100, 32'd7);
    wait_done(cyc, bc, ov);
    tests++;
    if (cyc !== 33 || {bus.quo, bus.rem, bus.dvz} !== {32'd14, 32'd2, 1'b0}) begin
      fails++; $display("FAIL reset_mid_recover: edges=%0d quo=%h rem=%h dvz=%b, need 33 0000000e 00000002 0",
                        cyc, bus.quo, bus.rem, bus.dvz);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_edges();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/divider_32bit.md
# divider_32bit

Multi-cycle 32-bit restoring divider: the inverse of the adder_32bit add/subtract datapath, which it instantiates as its trial-subtract engine. It executes MIPS-style `div` and `divu`, producing quotient (LO) and remainder (HI) one quotient bit per clock under a start/busy/done handshake. It sits beside the single-cycle ALU and stalls the core while `busy` is high.

## Interface
- size, 32, operand width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- sign  in  1  1 = signed (`div`), 0 = unsigned (`divu`); sampled with `start`.
- A  in  32  dividend; sampled with `start`.
- B  in  32  divisor; sampled with `start`.
- quo  out  32  quotient, valid from `done` until the next accepted `start`.
- rem  out  32  remainder, same validity as `quo`.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle completion pulse.
- dvz  out  1  divide-by-zero flag, valid with `quo`.

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE/DONE with start=1:
  - Latch the magnitudes of A and B (two's-complement negate when sign=1 and the MSB is 1), the sign bits, and the raw A.
  - Clear the partial remainder and the 6-bit iteration counter.
  - Go to CALC.
- IDLE/DONE with start=0: hold state. DONE returns to IDLE after one cycle.
- CALC, one iteration per cycle:
  - Shift {rem, quotient-shift} left 1; dividend MSB enters rem[0].
  - Trial = shifted rem − divisor, computed by adder_32bit with Ctr=1.
  - If sltu=0 (no borrow): rem ← trial, new quotient bit = 1. Otherwise rem is kept, quotient bit = 0.
  - Counter increments. After the 32nd iteration go to DONE.
- Entering DONE, registered results:
  - If divisor = 0: quo = 0xFFFFFFFF, rem = raw A, dvz = 1. Identical for signed and unsigned.
  - Otherwise dvz = 0.
  - quo is negated if sign=1 and the operand signs differ.
  - rem is negated if sign=1 and the dividend was negative. The remainder takes the dividend's sign.
  - Signed 0x80000000 / 0xFFFFFFFF gives quo = 0x80000000, rem = 0 with no special case (wraps). There is no overflow flag.
- start during CALC is ignored; operands are not re-sampled.
- A, B, and sign may change after the sampling edge without effect.

## Timing
- Edge E0 samples start. Iterations occur on E1..E32.
- E33 registers quo/rem/dvz and sets done=1, busy=0.
- E34 clears done.
- Latency from start edge to done is 33 cycles. Throughput is one operation per 34 cycles; back-to-back is allowed by asserting start during the DONE cycle.
- busy is 1 from E0 through E33 (exclusive), i.e. 33 cycles high. busy and done are never both high.
- quo/rem/dvz hold their last result until E33 of the next operation. They do not change at start.
- rst_n low, at any time including mid-CALC:
  - Immediately (asynchronously) forces IDLE.
  - quo = 0, rem = 0, busy = 0, done = 0, dvz = 0. The counter and internal registers are cleared.
  - The first start after rst_n deasserts behaves as from power-up.
- All outputs are registered; no combinational path exists from inputs to outputs.

## Test plan
- Unsigned: sign=0, A=100, B=7, start for 1 cycle → busy for 33 cycles, then done for 1 cycle with quo=14, rem=2, dvz=0. Check the exact edge count.
- Signed: sign=1, A=0xFFFFFF9C (−100), B=7 → quo=0xFFFFFFF2 (−14), rem=0xFFFFFFFE (−2). Repeat with A=100, B=0xFFFFFFF9 → quo=0xFFFFFFF2, rem=2.
- Divide by zero: A=0x12345678, B=0, sign=0 and then sign=1 → quo=0xFFFFFFFF, rem=0x12345678, dvz=1 in both cases.
- Edge operands:
  - A=0x80000000, B=0xFFFFFFFF, sign=1 → quo=0x80000000, rem=0.
  - Same operands with sign=0 → quo=0, rem=0x80000000.
  - A=0xFFFFFFFF, B=1, sign=0 → quo=0xFFFFFFFF, rem=0.
- Handshake:
  - Pulse start again at iteration 10 with different operands → ignored; the first result is returned.
  - Assert start in the DONE cycle → second operation accepted, done 33 cycles later.
- Reset mid-operation: drop rst_n asynchronously at iteration 16 → all outputs 0 immediately, no done. After release, 100/7 completes normally with quo=14, rem=2.
